// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash bus arbiter: FSM encoding, port indices,
// default widths and the grant-selection helper.
package flash_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 15;
    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned STRB_W     = 4;

    // Port indices: instruction fetch and data
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // One-hot FSM encoding
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        BUSY    = 3'b010,
        RESPOND = 3'b100
    } state_t;

    // Round-robin pick: a lone requester wins, a tie goes to the port not served last
    function automatic logic pick_port(input logic v0, input logic v1, input logic last);
        logic port;
        port = v1 ? PORT_D : PORT_I;
        if (v0 && v1) begin
            port = ~last;
        end
        return port;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, reset (async, active-high), clr (sync clear, wins over inc),
//        inc (count enable), count (current value, sticks at all-ones).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/flash_bus_arbiter.sv
// Round-robin arbiter sharing the user-flash cache controller between the
// instruction-fetch port (0) and data port (1), plus profiling counters.
// Ports: clk, reset (async, active-high);
//        reqN_valid/wstrb/addr/wdata in, reqN_ready/rdata out (N = 0, 1);
//        mem_select/wstrb/addr/wdata out (registered command),
//        mem_ready/rdata/cache_hit/cache_miss in;
//        clear_counters in; hit_count/miss_count/busy_cycles out.
module flash_bus_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [3:0]        req0_wstrb,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ready,
    output logic [31:0]       req0_rdata,
    input  logic              req1_valid,
    input  logic [3:0]        req1_wstrb,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ready,
    output logic [31:0]       req1_rdata,
    output logic              mem_select,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_cache_hit,
    input  logic              mem_cache_miss,
    input  logic              clear_counters,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  busy_cycles
);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                gnt_q, gnt_d;
    logic                sel_q, sel_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ready0_q, ready0_d;
    logic                ready1_q, ready1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                port;

    // State and output registers; last_grant resets to port 1 so port 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= PORT_D;
            gnt_q    <= PORT_I;
            sel_q    <= 1'b0;
            wstrb_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ready0_q <= ready0_d;
            ready1_q <= ready1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ready0_d = 1'b0;
        ready1_d = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        port     = pick_port(req0_valid, req1_valid, last_q);

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    gnt_d   = port;
                    last_d  = port;
                    sel_d   = 1'b1;
                    wstrb_d = (port == PORT_D) ? req1_wstrb : req0_wstrb;
                    addr_d  = (port == PORT_D) ? req1_addr  : req0_addr;
                    wdata_d = (port == PORT_D) ? req1_wdata : req0_wdata;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Drop select with the done pulse so the idle downstream block cannot retrigger
                if (mem_ready) begin
                    sel_d = 1'b0;
                    if (gnt_q == PORT_D) begin
                        rdata1_d = mem_rdata;
                        ready1_d = 1'b1;
                    end else begin
                        rdata0_d = mem_rdata;
                        ready0_d = 1'b1;
                    end
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                // Requests are not sampled here: the served port is still dropping valid
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign req0_rdata = rdata0_q;
    assign req1_rdata = rdata1_q;
    assign mem_select = sel_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_counters),
        .inc   (mem_cache_hit),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_counters),
        .inc   (mem_cache_miss),
        .count (miss_count)
    );

    sat_counter #(.W(CNT_W)) u_busy_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_counters),
        .inc   (state_q == BUSY),
        .count (busy_cycles)
    );

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter: a 32-bit-counter instance carries the
// main checks, a 4-bit-counter instance on the same stimulus shows saturation.
module tb_flash_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_wstrb, req1_wstrb;
    logic [14:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        mem_ready, mem_cache_hit, mem_cache_miss, clear_counters;
    logic [31:0] mem_rdata;

    logic        req0_ready, req1_ready, mem_select;
    logic [31:0] req0_rdata, req1_rdata, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [14:0] mem_addr;
    logic [31:0] hit_count, miss_count, busy_cycles;

    logic        x_ready0, x_ready1, x_sel;
    logic [31:0] x_rdata0, x_rdata1, x_wdata;
    logic [3:0]  x_wstrb;
    logic [14:0] x_addr;
    logic [3:0]  x_hit, x_miss, x_busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    flash_bus_arbiter #(.ADDR_W(15), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_wstrb(req0_wstrb), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_wstrb(req1_wstrb), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .mem_select(mem_select), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_cache_hit(mem_cache_hit), .mem_cache_miss(mem_cache_miss),
        .clear_counters(clear_counters), .hit_count(hit_count),
        .miss_count(miss_count), .busy_cycles(busy_cycles)
    );

    flash_bus_arbiter #(.ADDR_W(15), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_wstrb(req0_wstrb), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(x_ready0), .req0_rdata(x_rdata0),
        .req1_valid(req1_valid), .req1_wstrb(req1_wstrb), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(x_ready1), .req1_rdata(x_rdata1),
        .mem_select(x_sel), .mem_wstrb(x_wstrb), .mem_addr(x_addr),
        .mem_wdata(x_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_cache_hit(mem_cache_hit), .mem_cache_miss(mem_cache_miss),
        .clear_counters(clear_counters), .hit_count(x_hit),
        .miss_count(x_miss), .busy_cycles(x_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Downstream done pulse after lat further cycles; ends in the RESPOND cycle
    task automatic serve(input int unsigned lat, input logic [31:0] d, input logic hit);
        repeat (lat) tick();
        mem_ready      = 1'b1;
        mem_rdata      = d;
        mem_cache_hit  = hit;
        mem_cache_miss = ~hit;
        tick();
        mem_ready      = 1'b0;
        mem_cache_hit  = 1'b0;
        mem_cache_miss = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [14:0] a0, a1, held;
        logic        stable;
        logic        ep;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_wstrb = 4'h0; req1_wstrb = 4'h0;
        req0_addr = '0; req1_addr = '0;
        req0_wdata = '0; req1_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        mem_cache_hit = 1'b0; mem_cache_miss = 1'b0;
        clear_counters = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset values
        chk("rst_sel",   32'(mem_select), 32'd0);
        chk("rst_addr",  32'(mem_addr),   32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        chk("rst_rdata0", req0_rdata, 32'd0);
        chk("rst_busy",  busy_cycles, 32'd0);

        // mem_ready outside BUSY does nothing
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ready = 1'b0;
        tick();
        chk("stray_ready", 32'({req0_ready, req1_ready, mem_select}), 32'd0);
        chk("stray_rdata", req0_rdata, 32'd0);

        // Single read on port 0, hit
        req0_valid = 1'b1; req0_addr = 15'h0012; req0_wdata = 32'h0000_5555;
        tick();
        chk("t1_sel",    32'(mem_select), 32'd1);
        chk("t1_addr",   32'(mem_addr),   32'h0012);
        chk("t1_wstrb",  32'(mem_wstrb),  32'd0);
        chk("t1_wdata",  mem_wdata,       32'h0000_5555);
        chk("t1_x_cmd",  {x_wdata[15:0], 1'b0, x_addr}, {16'h5555, 16'h0012});
        chk("t1_x_sel",  32'({x_sel, x_wstrb}), 32'h10);
        serve(1, 32'h1234_5678, 1'b1);
        chk("t1_ready0", 32'(req0_ready), 32'd1);
        chk("t1_rdata0", req0_rdata,      32'h1234_5678);
        chk("t1_ready1", 32'(req1_ready), 32'd0);
        chk("t1_sel_lo", 32'(mem_select), 32'd0);
        chk("t1_hit",    hit_count,       32'd1);
        chk("t1_busy",   busy_cycles,     32'd2);
        chk("t1_x_rsp",  {x_rdata0[27:0], x_ready0, x_ready1, 2'b00}, {28'h234_5678, 4'b1000});
        chk("t1_x_rd1",  x_rdata1, 32'd0);
        chk("t1_x_cnt",  32'({x_hit, x_miss, x_busy}), 32'h102);
        tick();
        chk("t1_pulse",  32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        tick();
        chk("t1_noregrant", 32'(mem_select), 32'd0);

        // Tie right after reset: port 0 first, then port 1
        do_reset();
        req0_valid = 1'b1; req0_addr = 15'h0100;
        req1_valid = 1'b1; req1_addr = 15'h0200;
        tick();
        chk("t2_addr0",  32'(mem_addr), 32'h0100);
        serve(1, 32'hAAAA_0000, 1'b1);
        chk("t2_ready0", 32'({req0_ready, req1_ready}), 32'b10);
        chk("t2_rdata1", req1_rdata, 32'd0);
        tick();
        chk("t2_gap",    32'(mem_select), 32'd0);
        req0_valid = 1'b0;
        tick();
        chk("t2_sel1",   32'(mem_select), 32'd1);
        chk("t2_addr1",  32'(mem_addr),   32'h0200);
        serve(1, 32'hBBBB_1111, 1'b1);
        chk("t2_ready1", 32'({req0_ready, req1_ready}), 32'b01);
        chk("t2_rd1",    req1_rdata, 32'hBBBB_1111);
        chk("t2_rd0",    req0_rdata, 32'hAAAA_0000);
        tick();
        req1_valid = 1'b0;
        tick();

        // Long miss on port 1 while port 0 changes its pending address
        clear_counters = 1'b1;
        tick();
        clear_counters = 1'b0;
        req1_valid = 1'b1; req1_addr = 15'h3ABC;
        tick();
        chk("t3_addr", 32'(mem_addr), 32'h3ABC);
        req0_valid = 1'b1; req0_addr = 15'h0111;
        held   = mem_addr;
        stable = 1'b1;
        for (int i = 0; i < 65; i++) begin
            if (i == 20) req0_addr = 15'h0222;
            tick();
            if (mem_addr !== held || mem_select !== 1'b1) stable = 1'b0;
        end
        chk("t3_stable", 32'(stable), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_CAFE; mem_cache_miss = 1'b1;
        tick();
        mem_ready = 1'b0; mem_cache_miss = 1'b0;
        chk("t3_ready1", 32'({req0_ready, req1_ready}), 32'b01);
        chk("t3_rdata1", req1_rdata,  32'h0BAD_CAFE);
        chk("t3_miss",   miss_count,  32'd1);
        chk("t3_hit",    hit_count,   32'd0);
        chk("t3_busy",   busy_cycles, 32'd66);
        chk("t3_x_busy_sat", 32'(x_busy), 32'hF);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("t3_next0",  32'(mem_addr), 32'h0222);
        serve(1, 32'h0000_0222, 1'b1);
        chk("t3_ready0", 32'(req0_ready), 32'd1);
        chk("t3_x_busy_hold", 32'(x_busy), 32'hF);
        tick();
        req0_valid = 1'b0;
        tick();

        // Continuous requests from both ports alternate 0,1,0,1...
        do_reset();
        a0 = 15'h0A00; a1 = 15'h0B00;
        req0_valid = 1'b1; req0_addr = a0;
        req1_valid = 1'b1; req1_addr = a1;
        for (int n = 0; n < 8; n++) begin
            ep = n[0];
            tick();
            chk("t4_sel",  32'(mem_select), 32'd1);
            chk("t4_addr", 32'(mem_addr), 32'(ep ? a1 : a0));
            serve(1, 32'hC0DE_0000 + 32'(n), 1'b1);
            chk("t4_ready", 32'({req0_ready, req1_ready}), ep ? 32'b01 : 32'b10);
            if (ep) begin
                a1 = a1 + 15'd1; req1_addr = a1;
            end else begin
                a0 = a0 + 15'd1; req0_addr = a0;
            end
            tick();
            chk("t4_gap", 32'(mem_select), 32'd0);
        end
        chk("t4_rd0",   req0_rdata,  32'hC0DE_0006);
        chk("t4_rd1",   req1_rdata,  32'hC0DE_0007);
        chk("t4_hit",   hit_count,   32'd8);
        chk("t4_busy",  busy_cycles, 32'd16);
        chk("t4_x_busy", 32'(x_busy), 32'hF);
        chk("t4_x_hit",  32'(x_hit),  32'h8);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        tick();

        // Clear wins over a same-cycle increment
        clear_counters = 1'b1; mem_cache_hit = 1'b1;
        tick();
        clear_counters = 1'b0; mem_cache_hit = 1'b0;
        chk("t5_clr_hit",  hit_count,   32'd0);
        chk("t5_clr_busy", busy_cycles, 32'd0);
        mem_cache_hit = 1'b1;
        tick();
        mem_cache_hit = 1'b0;
        chk("t5_hit1", hit_count, 32'd1);

        // Reset in BUSY, then a port 1 write completes
        req0_valid = 1'b1; req0_addr = 15'h0777;
        tick();
        chk("t6_busy_sel", 32'(mem_select), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_sel",   32'(mem_select), 32'd0);
        chk("t6_cmd",   32'({mem_addr, mem_wstrb}), 32'd0);
        chk("t6_rdata", req0_rdata ^ req1_rdata ^ mem_wdata, 32'd0);
        chk("t6_cnt",   hit_count | miss_count | busy_cycles, 32'd0);
        tick();
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_addr = 15'h1234; req1_wstrb = 4'b0011; req1_wdata = 32'hDEAD_BEEF;
        tick();
        chk("t6_wsel",  32'(mem_select), 32'd1);
        chk("t6_waddr", 32'(mem_addr),   32'h1234);
        chk("t6_wstrb", 32'(mem_wstrb),  32'h3);
        chk("t6_wdata", mem_wdata,       32'hDEAD_BEEF);
        serve(1, 32'h0000_0000, 1'b1);
        chk("t6_ready1", 32'({req0_ready, req1_ready}), 32'b01);
        chk("t6_busy",   busy_cycles, 32'd2);
        tick();
        req1_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/flash_bus_arbiter.md
# flash_bus_arbiter

Two-port arbiter that shares the single user-flash cache controller between the picoRV instruction-fetch port (port 0) and data port (port 1). It grants one request at a time with round-robin fairness. It holds the downstream address and strobes stable for the whole flash transaction and returns the result to the granted requester only. It also keeps saturating cache hit/miss/busy counters for firmware profiling. It sits between the CPU memory decoder and `user_flash_custom`; the top level drives that block's `reset_n` from `~reset`.

## Interface
- `ADDR_W`, 15: word address width, passed to the downstream 9b row / 6b column address.
- `CNT_W`, 32: width of each statistics counter.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `req0_valid` / `req1_valid` in 1: request; held high until that port's `ready` is seen.
- `req0_wstrb` / `req1_wstrb` in 4: byte strobes; 0 means read.
- `req0_addr` / `req1_addr` in ADDR_W: word address.
- `req0_wdata` / `req1_wdata` in 32: write data.
- `req0_ready` / `req1_ready` out 1: one-cycle completion pulse.
- `req0_rdata` / `req1_rdata` out 32: read data, valid while `ready` is high; holds its last value otherwise.
- `mem_select` out 1: downstream select.
- `mem_wstrb` out 4, `mem_addr` out ADDR_W, `mem_wdata` out 32: registered downstream command.
- `mem_ready` in 1: downstream one-cycle done pulse.
- `mem_rdata` in 32: downstream read data.
- `mem_cache_hit` in 1, `mem_cache_miss` in 1: downstream one-cycle event pulses.
- `clear_counters` in 1: synchronous clear of all counters.
- `hit_count` out CNT_W, `miss_count` out CNT_W, `busy_cycles` out CNT_W: statistics.

## Operation
- FSM states:
  - IDLE: sample both `valid` inputs.
    - Only one port valid: grant it.
    - Both valid: grant the port not equal to `last_grant`.
    - On any grant: latch that port's `wstrb`/`addr`/`wdata` into the `mem_*` registers, set `mem_select`=1, set `gnt`, update `last_grant`, go to BUSY.
  - BUSY: hold `mem_select` and all `mem_*` registers constant.
    - When `mem_ready`=1: capture `mem_rdata` into the granted port's `rdata`, set `mem_select`=0, go to RESPOND.
  - RESPOND: pulse the granted port's `ready` for this cycle only. Do not sample requests. Go to IDLE.
- The non-granted port sees `ready`=0 and an unchanged `rdata` for the whole transaction.
- A request that arrives during BUSY or RESPOND waits. No request is dropped.
- Write requests (`wstrb`≠0) are forwarded unchanged. The downstream block acknowledges them without effect, so `rdata` is don't-care but is still captured.
- `mem_ready` outside BUSY is ignored. It does not change state or outputs.
- Counters:
  - `hit_count` +1 per `mem_cache_hit` cycle.
  - `miss_count` +1 per `mem_cache_miss` cycle.
  - `busy_cycles` +1 per cycle in BUSY.
  - All saturate at all-ones. There is no wrap.
  - `clear_counters` has priority over increment in the same cycle.
- Reset values:
  - FSM in IDLE, `last_grant`=1 (so port 0 wins the first tie).
  - `mem_select`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0.
  - Both `ready`=0, both `rdata`=0.
  - All counters 0.
- Reset mid-transaction: everything returns to the reset values immediately. The downstream block is reset by the same signal, so no stale `mem_ready` can follow.

## Timing
- Latency is counted from edge 0, where IDLE samples `valid`:
  - `mem_select` is high from cycle 1.
  - Downstream hit: `mem_ready` in cycle 2, requester `ready` in cycle 3.
  - Miss: requester `ready` is the cycle after `mem_ready`.
- `mem_select` is low in the cycle after `mem_ready`. This prevents the downstream block, which is back in idle that cycle, from re-triggering.
- The RESPOND cycle absorbs the requester's one-cycle delay in dropping `valid`, so a stale request is never regranted.
- Minimum spacing between two grants is 3 cycles (IDLE→BUSY→RESPOND).
- Back-to-back requests from both ports alternate 0,1,0,1.

## Structure
- Package `flash_arb_pkg`: FSM state one-hot localparams (IDLE, BUSY, RESPOND), port index constants `PORT_I`=0 and `PORT_D`=1, default widths.
- Sub-module `sat_counter`, parameter `W`, ports `clk`, `reset`, `clr`, `inc`, `count`. Three instances are used.
- The arbiter FSM and command register stay in `flash_bus_arbiter`.

## Test plan
- Single read, port 0, `addr`=0x0012, downstream model hit returning 0x1234_5678 → `mem_select` at cycle 1; `req0_ready` pulse at cycle 3 with `req0_rdata`=0x1234_5678; `req1_ready` stays 0; `hit_count`=1.
- Both ports valid at the same edge right after reset, both reads → port 0 is served first. Port 1 is granted in the IDLE cycle after port 0's RESPOND. Port 1's `mem_addr` equals `req1_addr`.
- Miss on port 1 with the model holding `mem_ready` for 66 cycles; port 0 changes its request to a new address mid-wait → `mem_addr` stays stable throughout the wait; `miss_count`=1; `busy_cycles`=66; port 0 is granted next.
- Continuous requests from both ports for 8 transactions → grant order is 0,1,0,1,…; `mem_select` has a low cycle between transactions.
- Preload `busy_cycles` near saturation (CNT_W=4 build) → it holds at 0xF. `clear_counters` asserted together with `mem_cache_hit` → `hit_count`=0.
- Assert `reset` during BUSY → all outputs return to reset values in the same cycle. After release, a new port 1 request completes normally.
